// File: rtl/sample_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sample_mem_arbiter
// -----------------------------------------------------------------------------
// Shares the single read port of the PPG sample memory between NUM_REQ
// processing engines. Each engine posts a burst request (start address and
// length). The arbiter grants one engine at a time in round-robin order,
// generates the read addresses, and returns the samples tagged to the owning
// engine with valid / last / done strobes.
//
// Parameters
//   DATA_WIDTH    sample width
//   MEMORY_DEPTH  number of valid sample locations
//   ADDR_WIDTH    memory address width
//   NUM_REQ       number of requesters (index 0 has priority after reset)
//
// Ports
//   clk               clock
//   reset             synchronous, active-high reset
//   mem_loaded        memory initialised; no grants while low
//   req               level request, one bit per engine
//   req_start_addr    burst start, engine i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len           burst length, engine i at [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
//   mem_read_address  read address to the memory
//   mem_data_out      read data from the memory (one-cycle registered read)
//   grant             one-hot owner of the read port, 0 when idle
//   rd_data           returned sample, broadcast to all engines
//   rd_valid          one-hot: rd_data is valid for engine i
//   rd_last           qualifies the final sample of a burst
//   burst_done        one-cycle pulse, burst finished for engine i
//   range_err         one-cycle pulse, burst rejected as out of range
// -----------------------------------------------------------------------------
module sample_mem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 5968,
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_REQ      = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_loaded,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_start_addr,
    input  logic [NUM_REQ*(ADDR_WIDTH+1)-1:0] req_len,
    output logic [ADDR_WIDTH-1:0]             mem_read_address,
    input  logic [DATA_WIDTH-1:0]             mem_data_out,
    output logic [NUM_REQ-1:0]                grant,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [NUM_REQ-1:0]                rd_valid,
    output logic                              rd_last,
    output logic [NUM_REQ-1:0]                burst_done,
    output logic                              range_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LEN_W = ADDR_WIDTH + 1;
    // One extra bit over start+len so the range check can never wrap.
    localparam int SUM_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      owner_q;
    logic [LEN_W-1:0]      remaining_q;

    logic                  found_c;
    logic [IDX_W-1:0]      winner_c;
    int                    idx_c;
    logic [NUM_REQ-1:0]    win_onehot_c;
    logic [ADDR_WIDTH-1:0] win_start_c;
    logic [LEN_W-1:0]      win_len_c;
    logic [SUM_W-1:0]      win_end_c;
    logic                  len_zero_c;
    logic                  out_of_range_c;
    logic                  arb_c;
    logic                  accept_c;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin search: first asserted request at or after the pointer,
    // wrapping around the requester list.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        idx_c    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_c = (int'(ptr_q) + k) % NUM_REQ;
            if (!found_c && req[idx_c]) begin
                found_c  = 1'b1;
                winner_c = IDX_W'(idx_c);
            end
        end
    end

    // Decode the winner's burst and decide whether it can be served.
    always_comb begin
        win_onehot_c   = NUM_REQ'(1) << winner_c;
        win_start_c    = req_start_addr[int'(winner_c)*ADDR_WIDTH +: ADDR_WIDTH];
        win_len_c      = req_len[int'(winner_c)*LEN_W +: LEN_W];
        win_end_c      = SUM_W'(win_start_c) + SUM_W'(win_len_c);
        len_zero_c     = (win_len_c == '0);
        out_of_range_c = !len_zero_c && (win_end_c > SUM_W'(MEMORY_DEPTH));
        // Arbitration is held off while a done pulse is showing, so an
        // engine whose burst was rejected has one cycle to drop its request.
        arb_c          = (state_q == IDLE) && mem_loaded && found_c && (burst_done == '0);
        accept_c       = arb_c && !len_zero_c && !out_of_range_c;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (remaining_q <= LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered strobes. Valid/last/done are raised while the
    // address is on the bus so they line up with the memory's one-cycle
    // read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q            <= '0;
            owner_q          <= '0;
            remaining_q      <= '0;
            mem_read_address <= '0;
            grant            <= '0;
            rd_valid         <= '0;
            rd_last          <= 1'b0;
            burst_done       <= '0;
            range_err        <= 1'b0;
        end else begin
            rd_valid   <= '0;
            rd_last    <= 1'b0;
            burst_done <= '0;
            range_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        grant            <= win_onehot_c;
                        owner_q          <= winner_c;
                        mem_read_address <= win_start_c;
                        remaining_q      <= win_len_c;
                    end else if (arb_c) begin
                        // Rejected burst: answer with done, and move the
                        // winner to lowest priority like a completed burst.
                        burst_done <= win_onehot_c;
                        range_err  <= out_of_range_c;
                        ptr_q      <= next_ptr(winner_c);
                    end
                end
                ISSUE: begin
                    rd_valid <= grant;
                    if (remaining_q > LEN_W'(1)) begin
                        mem_read_address <= mem_read_address + 1'b1;
                        remaining_q      <= remaining_q - 1'b1;
                    end else begin
                        rd_last    <= 1'b1;
                        burst_done <= grant;
                    end
                end
                DRAIN: begin
                    grant <= '0;
                    ptr_q <= next_ptr(owner_q);
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    // Memory data is only meaningful while a valid strobe is up.
    assign rd_data = (|rd_valid) ? mem_data_out : '0;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sample_mem_arbiter
// -----------------------------------------------------------------------------
// Self-checking bench for sample_mem_arbiter. A behavioural memory returns
// mem[i] = i + 10 one cycle after the address. Every stimulus step pushes the
// expected per-cycle output vector to a scoreboard queue; each cycle the bench
// pops one entry at the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sample_mem_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 5968;
    localparam int AW    = 13;
    localparam int NR    = 3;
    localparam int LW    = AW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_loaded;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_start_addr;
    logic [NR*LW-1:0]  req_len;
    logic [AW-1:0]     mem_read_address;
    logic [DW-1:0]     mem_data_out;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     rd_data;
    logic [NR-1:0]     rd_valid;
    logic              rd_last;
    logic [NR-1:0]     burst_done;
    logic              range_err;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [NR-1:0] rd_valid;
        logic [DW-1:0] rd_data;
        logic          rd_last;
        logic [NR-1:0] burst_done;
        logic          range_err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sample_mem_arbiter #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(DEPTH),
        .ADDR_WIDTH  (AW),
        .NUM_REQ     (NR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_loaded      (mem_loaded),
        .req             (req),
        .req_start_addr  (req_start_addr),
        .req_len         (req_len),
        .mem_read_address(mem_read_address),
        .mem_data_out    (mem_data_out),
        .grant           (grant),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_last         (rd_last),
        .burst_done      (burst_done),
        .range_err       (range_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input int a);
        return DW'(a + 10);
    endfunction

    // Registered-read sample memory.
    always @(posedge clk) begin
        mem_data_out <= memval(int'(mem_read_address));
    end

    task automatic checkOutput(input string tag, input exp_t obs, input exp_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: pop the expected vector and compare at the falling edge.
    task automatic stepCheck(input string tag);
        exp_t e;
        exp_t o;
        @(negedge clk);
        e = (sb.size() == 0) ? exp_t'(0) : sb.pop_front();
        o.grant      = grant;
        o.rd_valid   = rd_valid;
        o.rd_data    = (e.rd_valid == '0) ? '0 : rd_data;
        o.rd_last    = rd_last;
        o.burst_done = burst_done;
        o.range_err  = range_err;
        checkOutput(tag, o, e);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            stepCheck(tag);
        end
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exp_t'(0));
        end
    endtask

    task automatic pushBurst(input int eng, input int start, input int len);
        exp_t e;
        e       = '0;
        e.grant = NR'(1) << eng;
        sb.push_back(e);
        for (int k = 0; k < len; k++) begin
            e.rd_valid   = NR'(1) << eng;
            e.rd_data    = memval(start + k);
            e.rd_last    = (k == len - 1);
            e.burst_done = (k == len - 1) ? (NR'(1) << eng) : '0;
            sb.push_back(e);
        end
    endtask

    task automatic pushReject(input int eng, input logic rerr);
        exp_t e;
        e            = '0;
        e.burst_done = NR'(1) << eng;
        e.range_err  = rerr;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input int eng,
                                 input int start, input int len);
        req_start_addr[eng*AW +: AW] = AW'(start);
        req_len[eng*LW +: LW]        = LW'(len);
        req                          = r;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset          = 1'b1;
        mem_loaded     = 1'b1;
        req            = '0;
        req_start_addr = '0;
        req_len        = '0;

        // Reset state
        pushIdle(3);
        steps(3, "reset_state");
        reset = 1'b0;
        pushIdle(1);
        steps(1, "post_reset_idle");

        // Single burst on engine 0; dropping req mid-burst is ignored
        applyStimulus(3'b001, 0, 0, 4);
        pushBurst(0, 0, 4);
        pushIdle(2);
        steps(1, "t1_grant");
        req = '0;
        steps(6, "t1_burst");

        reset = 1'b1;
        pushIdle(2);
        steps(2, "mid_reset");
        reset = 1'b0;

        // Round-robin with all requests held
        applyStimulus(3'b111, 0, 100, 2);
        applyStimulus(3'b111, 1, 200, 2);
        applyStimulus(3'b111, 2, 300, 2);
        pushBurst(0, 100, 2);
        pushIdle(1);
        pushBurst(1, 200, 2);
        pushIdle(1);
        pushBurst(2, 300, 2);
        pushIdle(1);
        pushBurst(0, 100, 2);
        steps(15, "t2_rr");
        req = '0;
        pushIdle(2);
        steps(2, "t2_tail");

        // Range boundary: last two locations accepted
        applyStimulus(3'b001, 0, 5966, 2);
        pushBurst(0, 5966, 2);
        pushIdle(1);
        steps(1, "t3_edge_grant");
        req = '0;
        steps(3, "t3_edge_burst");

        // One past the end is rejected
        applyStimulus(3'b001, 0, 5967, 2);
        pushReject(0, 1'b1);
        pushIdle(2);
        steps(1, "t3_range_err");
        req = '0;
        steps(2, "t3_after_err");

        // Final location alone is accepted
        applyStimulus(3'b001, 0, 5967, 1);
        pushBurst(0, 5967, 1);
        pushIdle(1);
        steps(1, "t3_last_grant");
        req = '0;
        steps(2, "t3_last_burst");

        // Zero-length burst
        applyStimulus(3'b001, 0, 50, 0);
        pushReject(0, 1'b0);
        pushIdle(2);
        steps(1, "t4_len0_done");
        req = '0;
        steps(2, "t4_after");

        // Memory not loaded: request held off
        mem_loaded = 1'b0;
        applyStimulus(3'b001, 0, 20, 2);
        pushIdle(6);
        steps(6, "t5_not_loaded");
        mem_loaded = 1'b1;
        pushBurst(0, 20, 2);
        pushIdle(1);
        steps(1, "t5_grant");
        req = '0;
        steps(3, "t5_burst");

        // Reset at the third sample of a long burst aborts it
        applyStimulus(3'b001, 0, 100, 8);
        pushBurst(0, 100, 8);
        steps(4, "t6_before_reset");
        req   = '0;
        reset = 1'b1;
        sb.delete();
        pushIdle(3);
        steps(3, "t6_in_reset");
        reset = 1'b0;
        pushIdle(1);
        steps(1, "t6_released");

        // Pointer restarts at engine 0
        applyStimulus(3'b111, 0, 40, 1);
        applyStimulus(3'b111, 1, 60, 1);
        applyStimulus(3'b111, 2, 80, 1);
        pushBurst(0, 40, 1);
        pushIdle(2);
        steps(1, "t6_ptr_grant");
        req = '0;
        steps(3, "t6_ptr_burst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
